// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM states,
// legal access-latency bounds and the control pattern used for bubbles.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 8;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    // Control bits loaded into MEM/WB while an access is still in flight,
    // so the writeback stage sees a harmless no-op.
    localparam wb_ctrl_t BUBBLE_CTRL = '{regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/dmem_ram.sv
// Data-memory word array, DEPTH x 32. Writes happen on the rising edge;
// the addressed word is presented continuously so the caller can capture
// it on the same edge that completes the access (pre-write value).
module dmem_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: loads/stores against an internal word RAM with a
// configurable latency, branch resolution, and the MEM/WB register.
// Optional feature macro: MEM_STAGE_MISALIGN_CHK_EN (flags accesses whose
// byte address is not word aligned and suppresses their side effects).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        branch_in,
    input  logic        zflag_in,
    input  logic [31:0] branch_result_in,
    input  logic [31:0] alures_in,
    input  logic [31:0] data2_in,
    input  logic [4:0]  instruccion_in,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [31:0] readdata_out,
    output logic [31:0] alures_out,
    output logic [4:0]  instruccion_out,
    output logic        pcsrc_out,
    output logic [31:0] branch_target_out,
    output logic        stall_out,
    output logic        misalign_out
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic               mem_op;
    logic               complete;
    logic               stall;
    logic               misaligned;
    logic               ram_we;
    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        ram_rdata;

    assign mem_op   = memread_in | memwrite_in;
    assign word_idx = alures_in[ADDR_W+1:2];

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    assign misaligned = mem_op & (alures_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A store and a simultaneous read/write both count as a write; misaligned
    // stores are dropped when the alignment check is built in.
    assign ram_we = complete & memwrite_in & ~misaligned;

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (data2_in),
        .rdata (ram_rdata)
    );

    // State and latency counter; an asynchronous reset aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: decide whether this edge completes an access or
    // whether the front of the pipeline must be held for another cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (LAT == 1) begin
                        complete = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        next_state = BUSY;
                        next_cnt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt > CNT_ONE) begin
                    stall    = 1'b1;
                    next_cnt = cnt - CNT_ONE;
                end else begin
                    complete   = 1'b1;
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Stall is masked by reset so it drops the moment reset is asserted,
    // even while upstream is still presenting the aborted access.
    assign stall_out = stall & rst_n;

    assign pcsrc_out         = branch_in & zflag_in;
    assign branch_target_out = branch_result_in;

    // MEM/WB register: pass-through on plain ALU cycles, full update on
    // access completion, bubble (control cleared, data held) while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_out    <= 1'b0;
            memtoreg_out    <= 1'b0;
            readdata_out    <= '0;
            alures_out      <= '0;
            instruccion_out <= '0;
        end else if (complete) begin
            regwrite_out    <= regwrite_in & ~misaligned;
            memtoreg_out    <= memtoreg_in;
            alures_out      <= alures_in;
            instruccion_out <= instruccion_in;
            if (memread_in) begin
                readdata_out <= ram_rdata;
            end
        end else if (state == IDLE && !mem_op) begin
            regwrite_out    <= regwrite_in;
            memtoreg_out    <= memtoreg_in;
            alures_out      <= alures_in;
            instruccion_out <= instruccion_in;
        end else begin
            {regwrite_out, memtoreg_out} <= BUBBLE_CTRL;
        end
    end

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    // Misalignment flag follows each completed access and clears on
    // plain ALU cycles; it holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_out <= 1'b0;
        end else if (complete) begin
            misalign_out <= misaligned;
        end else if (state == IDLE && !mem_op) begin
            misalign_out <= 1'b0;
        end
    end
`else
    assign misalign_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one instance at the default latency
// of 2 and one at latency 4, driven from shared inputs. Expected MEM/WB
// contents come from a small RAM model and are queued when driven.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        regwrite_in = 0, memtoreg_in = 0, memwrite_in = 0, memread_in = 0;
    logic        branch_in = 0, zflag_in = 0;
    logic [31:0] branch_result_in = '0, alures_in = '0, data2_in = '0;
    logic [4:0]  instruccion_in = '0;

    logic        regwrite2, memtoreg2, pcsrc2, stall2, misalign2;
    logic [31:0] readdata2, alures2, target2;
    logic [4:0]  instr2;
    logic        regwrite4, memtoreg4, pcsrc4, stall4, misalign4;
    logic [31:0] readdata4, alures4, target4;
    logic [4:0]  instr4;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram2 [256];
    logic [31:0] ram4 [256];
    logic [31:0] rdm2 = '0, rdm4 = '0;
    logic [70:0] obs2, obs4;
    int          errors = 0;
    int          checks = 0;

    assign obs2 = {regwrite2, memtoreg2, readdata2, alures2, instr2};
    assign obs4 = {regwrite4, memtoreg4, readdata4, alures4, instr4};

    always #5 clk = ~clk;

    mem_stage #(.MEM_LAT(2), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .memwrite_in(memwrite_in), .memread_in(memread_in),
        .branch_in(branch_in), .zflag_in(zflag_in),
        .branch_result_in(branch_result_in), .alures_in(alures_in),
        .data2_in(data2_in), .instruccion_in(instruccion_in),
        .regwrite_out(regwrite2), .memtoreg_out(memtoreg2),
        .readdata_out(readdata2), .alures_out(alures2),
        .instruccion_out(instr2), .pcsrc_out(pcsrc2),
        .branch_target_out(target2), .stall_out(stall2),
        .misalign_out(misalign2)
    );

    mem_stage #(.MEM_LAT(4), .DEPTH(256)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .memwrite_in(memwrite_in), .memread_in(memread_in),
        .branch_in(branch_in), .zflag_in(zflag_in),
        .branch_result_in(branch_result_in), .alures_in(alures_in),
        .data2_in(data2_in), .instruccion_in(instruccion_in),
        .regwrite_out(regwrite4), .memtoreg_out(memtoreg4),
        .readdata_out(readdata4), .alures_out(alures4),
        .instruccion_out(instr4), .pcsrc_out(pcsrc4),
        .branch_target_out(target4), .stall_out(stall4),
        .misalign_out(misalign4)
    );

    // Drive one operation at a negedge, predict its MEM/WB result into the
    // scoreboard, then wait (bounded) until the completing edge has passed.
    task automatic run_op(input int lat, input logic mr, input logic mw,
                          input logic rw, input logic mtr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, output int stalls, output logic timeout);
        logic [7:0]  idx;
        logic        mis;
        logic [31:0] old;
        exp_t        e;
        memread_in = mr; memwrite_in = mw; regwrite_in = rw; memtoreg_in = mtr;
        alures_in = addr; data2_in = data; instruccion_in = rd;
        idx = addr[9:2];
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        mis = (mr | mw) && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        old = (lat == 4) ? ram4[idx] : ram2[idx];
        if (mr) begin
            if (lat == 4) rdm4 = old; else rdm2 = old;
        end
        if (mw && !mis) begin
            if (lat == 4) ram4[idx] = data; else ram2[idx] = data;
        end
        e = '{rw: rw & ~mis, mtr: mtr, rdata: (lat == 4) ? rdm4 : rdm2, alu: addr, rd: rd};
        sb.push_back(e);
        stalls  = 0;
        timeout = 1'b1;
        for (int c = 0; c < 20; c++) begin
            logic s;
            #1 s = (lat == 4) ? stall4 : stall2;
            if (s) stalls++;
            @(posedge clk);
            if (!s) begin
                timeout = 1'b0;
                break;
            end
        end
        @(negedge clk);
        memread_in = 1'b0; memwrite_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        memread_in = 0; memwrite_in = 0; regwrite_in = 0; memtoreg_in = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdm2 = '0; rdm4 = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        int   st;
        logic to;
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs2 !== 71'd0 || misalign2 !== 1'b0 || stall2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_lat2: got %h mis=%b stall=%b, want all zero", obs2, misalign2, stall2);
        end
        checks++;
        if (obs4 !== 71'd0 || misalign4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_lat4: got %h mis=%b, want all zero", obs4, misalign4);
        end
        rst_n = 1'b1;
        run_op(4, 0, 1, 0, 0, 32'h10, 32'h11111111, 5'd0, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs4 !== e) begin
            errors++;
            $display("[TB] FAIL reset_setup_store: got %h to=%b, want %h", obs4, to, e);
        end
        memwrite_in = 1'b1; alures_in = 32'h10; data2_in = 32'h22222222;
        #1;
        checks++;
        if (stall4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_busy_stall: got %b, want 1", stall4);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall4 !== 1'b0 || obs4 !== 71'd0) begin
            errors++;
            $display("[TB] FAIL reset_abort: stall=%b outs=%h, want 0 and zero", stall4, obs4);
        end
        @(posedge clk);
        @(negedge clk);
        memwrite_in = 1'b0;
        rst_n = 1'b1;
        rdm2 = '0; rdm4 = '0;
        run_op(4, 1, 0, 1, 1, 32'h10, 32'h0, 5'd2, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs4 !== e) begin
            errors++;
            $display("[TB] FAIL reset_ram_kept: got %h to=%b, want %h", obs4, to, e);
        end
        do_reset();
    endtask

    task automatic test_store_load();
        int   st;
        logic to;
        exp_t e;
        run_op(2, 0, 1, 0, 0, 32'h20, 32'hDEADBEEF, 5'd3, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || st !== 1 || obs2 !== e) begin
            errors++;
            $display("[TB] FAIL store_lat2: got %h stalls=%0d, want %h stalls=1", obs2, st, e);
        end
        run_op(2, 1, 0, 1, 1, 32'h20, 32'h0, 5'd7, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || st !== 1 || obs2 !== e) begin
            errors++;
            $display("[TB] FAIL load_lat2: got %h stalls=%0d, want %h stalls=1", obs2, st, e);
        end
    endtask

    task automatic test_passthrough();
        int   st;
        logic to;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(2, 0, 0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                   5'($urandom), st, to);
            e = sb.pop_front();
            checks++;
            if (to !== 1'b0 || st !== 0 || obs2 !== e) begin
                errors++;
                $display("[TB] FAIL passthrough_%0d: got %h stalls=%0d, want %h stalls=0", i, obs2, st, e);
            end
        end
    endtask

    task automatic test_alias();
        int   st;
        logic to;
        exp_t e;
        run_op(2, 0, 1, 0, 0, 32'h400, 32'h5A5A1234, 5'd1, st, to);
        e = sb.pop_front();
        run_op(2, 1, 0, 1, 1, 32'h0, 32'h0, 5'd4, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs2 !== e) begin
            errors++;
            $display("[TB] FAIL alias_load: got %h, want %h", obs2, e);
        end
        run_op(2, 1, 1, 1, 0, 32'h0, 32'h0BADF00D, 5'd6, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs2 !== e) begin
            errors++;
            $display("[TB] FAIL read_write_both: got %h, want %h", obs2, e);
        end
        run_op(2, 1, 0, 1, 1, 32'h400, 32'h0, 5'd8, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs2 !== e) begin
            errors++;
            $display("[TB] FAIL alias_reload: got %h, want %h", obs2, e);
        end
    endtask

    task automatic test_misalign();
        int   st;
        logic to;
        logic want;
        exp_t e;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        run_op(2, 0, 1, 1, 0, 32'h22, 32'h77777777, 5'd9, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || st !== 1 || obs2 !== e || misalign2 !== want) begin
            errors++;
            $display("[TB] FAIL misalign_store: got %h mis=%b, want %h mis=%b", obs2, misalign2, e, want);
        end
        run_op(2, 1, 0, 1, 1, 32'h20, 32'h0, 5'd10, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs2 !== e || misalign2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_readback: got %h mis=%b, want %h mis=0", obs2, misalign2, e);
        end
    endtask

    task automatic test_branch();
        branch_in = 1'b1; zflag_in = 1'b1; branch_result_in = 32'h40;
        #1;
        checks++;
        if (pcsrc2 !== 1'b1 || target2 !== 32'h40 || pcsrc4 !== 1'b1 || target4 !== 32'h40) begin
            errors++;
            $display("[TB] FAIL branch_taken: pcsrc=%b target=%h, want 1 00000040", pcsrc2, target2);
        end
        zflag_in = 1'b0;
        #1;
        checks++;
        if (pcsrc2 !== 1'b0 || pcsrc4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_not_taken: pcsrc=%b, want 0", pcsrc2);
        end
        branch_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lat4();
        int   st;
        int   bubbles;
        logic to;
        logic done;
        exp_t e;
        do_reset();
        run_op(4, 0, 1, 0, 0, 32'h30, 32'hCAFEF00D, 5'd11, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || st !== 3 || obs4 !== e) begin
            errors++;
            $display("[TB] FAIL store_lat4: got %h stalls=%0d, want %h stalls=3", obs4, st, e);
        end
        run_op(4, 0, 0, 1, 1, 32'h1234, 32'h0, 5'd9, st, to);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || obs4 !== e) begin
            errors++;
            $display("[TB] FAIL alu_lat4: got %h, want %h", obs4, e);
        end
        memread_in = 1'b1; regwrite_in = 1'b1; memtoreg_in = 1'b1;
        alures_in = 32'h30; instruccion_in = 5'd12;
        rdm4 = ram4[8'h0C];
        sb.push_back('{rw: 1'b1, mtr: 1'b1, rdata: rdm4, alu: 32'h30, rd: 5'd12});
        st = 0; bubbles = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            logic s;
            #1 s = stall4;
            if (s) st++;
            @(posedge clk);
            @(negedge clk);
            if (!s) done = 1'b1;
            else if (regwrite4 === 1'b0 && memtoreg4 === 1'b0 && alures4 === 32'h1234) bubbles++;
        end
        memread_in = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || st !== 3 || bubbles !== 3) begin
            errors++;
            $display("[TB] FAIL load_lat4_timing: stalls=%0d bubbles=%0d done=%b, want 3 3 1", st, bubbles, done);
        end
        checks++;
        if (obs4 !== e) begin
            errors++;
            $display("[TB] FAIL load_lat4_data: got %h, want %h", obs4, e);
        end
    endtask

    initial begin
        $display("[TB] mem_stage bench start");
        test_reset();
        test_store_load();
        test_passthrough();
        test_alias();
        test_misalign();
        test_branch();
        test_lat4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
